// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - N-phase traffic-light sequencer with night flash and key-set durations
// Optional feature: define ALLRED_EN to insert an all-red clearance state after every yellow.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode[1:0]             00 run, 01 night, 10 set green, 11 set yellow
//   set_phase             phase whose duration the keys edit in the set modes
//   key_plus, key_sub     raw keys, a press is a 1->0 edge after synchronisation
//   red/yellow/green      per-phase lamp drives
//   phase_o, state_o      active phase, state (0 NIGHT, 1 GREEN, 2 YELLOW, 3 ALLRED)
//   remain_o              seconds left in the current state
//   set_val_o             duration under edit (0 in run/night)
//   tick_o                one-cycle 1 s tick
module traffic_phase_ctrl #(
  parameter int N_PHASE    = 2,
  parameter int PH_W       = 3,
  parameter int CNT_W      = 11,
  parameter int GREEN_DEF  = 8,
  parameter int YELLOW_DEF = 6,
  parameter int ALLRED_DUR = 1,
  parameter int TICK_DIV   = 12_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [PH_W-1:0]    set_phase,
  input  logic               key_plus,
  input  logic               key_sub,
  output logic [N_PHASE-1:0] red,
  output logic [N_PHASE-1:0] yellow,
  output logic [N_PHASE-1:0] green,
  output logic [PH_W-1:0]    phase_o,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   remain_o,
  output logic [CNT_W-1:0]   set_val_o,
  output logic               tick_o
);

  typedef enum logic [1:0] {
    ST_NIGHT  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_t;

  localparam logic [1:0]       MODE_RUN   = 2'b00;
  localparam logic [1:0]       MODE_NIGHT = 2'b01;
  localparam int               PS_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALLRED_LD  = (ALLRED_DUR < 1) ? CNT_ONE : CNT_W'(ALLRED_DUR);
  localparam logic [PH_W-1:0]  LAST_PH    = PH_W'(N_PHASE - 1);

  state_t           state_q, nxt_state;
  logic [PH_W-1:0]  phase_q, nxt_phase, phase_inc;
  logic [CNT_W-1:0] cnt_q, cnt_run, cnt_d, load_val;
  logic             load, flash_q, flash_d;
  logic [PS_W-1:0]  presc_q;
  logic             tick;
  logic [2:0]       plus_sr, sub_sr;
  logic             plus_edge, sub_edge, edit_en;
  logic [CNT_W-1:0] green_dur  [N_PHASE];
  logic [CNT_W-1:0] yellow_dur [N_PHASE];
  logic [CNT_W-1:0] g_nxt, y_nxt, g_set, y_set;

  // Free-running prescaler; the tick is the last count of each period.
  assign tick = (presc_q == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PS_W'(1);
  end

  // Two sync flops plus one history flop per key; idle level is high so
  // leaving reset with a released key never produces a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plus_sr <= '1;
      sub_sr  <= '1;
    end else begin
      plus_sr <= {plus_sr[1:0], key_plus};
      sub_sr  <= {sub_sr[1:0], key_sub};
    end
  end

  assign plus_edge = plus_sr[2] & ~plus_sr[1];
  assign sub_edge  = sub_sr[2] & ~sub_sr[1];
  // Both keys at once cancel out; only the set modes accept edits.
  assign edit_en   = mode[1] & (plus_edge ^ sub_edge);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic up);
    if (up) return (v == CNT_MAX) ? v : v + CNT_ONE;
    else    return (v <= CNT_ONE) ? CNT_ONE : v - CNT_ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PHASE; i++) begin
        green_dur[i]  <= CNT_W'(GREEN_DEF);
        yellow_dur[i] <= CNT_W'(YELLOW_DEF);
      end
    end else if (edit_en) begin
      for (int i = 0; i < N_PHASE; i++) begin
        if (set_phase == PH_W'(i)) begin
          if (mode[0]) yellow_dur[i] <= bump(yellow_dur[i], plus_edge);
          else         green_dur[i]  <= bump(green_dur[i], plus_edge);
        end
      end
    end
  end

  // Duration lookups for the phase being entered and the phase being edited.
  always_comb begin
    g_nxt = '0;
    y_nxt = '0;
    g_set = '0;
    y_set = '0;
    for (int i = 0; i < N_PHASE; i++) begin
      if (nxt_phase == PH_W'(i)) begin
        g_nxt = green_dur[i];
        y_nxt = yellow_dur[i];
      end
      if (set_phase == PH_W'(i)) begin
        g_set = green_dur[i];
        y_set = yellow_dur[i];
      end
    end
  end

  always_comb begin
    case (nxt_state)
      ST_GREEN:  load_val = g_nxt;
      ST_YELLOW: load_val = y_nxt;
      ST_ALLRED: load_val = ALLRED_LD;
      default:   load_val = '0;
    endcase
  end

  assign phase_inc = (phase_q == LAST_PH) ? '0 : phase_q + PH_W'(1);

  // Set modes fall through every branch below, so FSM and counter hold.
  always_comb begin
    nxt_state = state_q;
    nxt_phase = phase_q;
    cnt_run   = cnt_q;
    load      = 1'b0;
    if (mode == MODE_NIGHT) begin
      nxt_state = ST_NIGHT;
      cnt_run   = '0;
    end else if (state_q == ST_NIGHT) begin
      if (mode == MODE_RUN) begin
        nxt_state = ST_GREEN;
        nxt_phase = '0;
        load      = 1'b1;
      end
    end else if (mode == MODE_RUN && tick) begin
      if (cnt_q > CNT_ONE) begin
        cnt_run = cnt_q - CNT_ONE;
      end else begin
        load = 1'b1;
        case (state_q)
          ST_GREEN: nxt_state = ST_YELLOW;
`ifdef ALLRED_EN
          ST_YELLOW: nxt_state = ST_ALLRED;
`else
          ST_YELLOW: begin
            nxt_state = ST_GREEN;
            nxt_phase = phase_inc;
          end
`endif
          default: begin
            nxt_state = ST_GREEN;
            nxt_phase = phase_inc;
          end
        endcase
      end
    end
  end

  assign cnt_d   = load ? load_val : cnt_run;
  assign flash_d = flash_q ^ (state_q == ST_NIGHT && tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NIGHT;
      phase_q <= '0;
      cnt_q   <= '0;
      flash_q <= 1'b0;
    end else begin
      state_q <= nxt_state;
      phase_q <= nxt_phase;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    case (state_q)
      ST_NIGHT: yellow = {N_PHASE{flash_q}};
      ST_GREEN, ST_YELLOW: begin
        for (int i = 0; i < N_PHASE; i++) begin
          if (phase_q == PH_W'(i)) begin
            green[i]  = (state_q == ST_GREEN);
            yellow[i] = (state_q == ST_YELLOW);
          end else begin
            red[i] = 1'b1;
          end
        end
      end
      default: red = '1;
    endcase
  end

  always_comb begin
    case (mode)
      2'b10:   set_val_o = g_set;
      2'b11:   set_val_o = y_set;
      default: set_val_o = '0;
    endcase
  end

  assign phase_o  = phase_q;
  assign state_o  = state_q;
  assign remain_o = cnt_q;
  assign tick_o   = tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - randomized self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

  localparam int N   = 3;
  localparam int PHW = 3;
  localparam int CW  = 11;
  localparam int GD  = 8;
  localparam int YD  = 6;
  localparam int AR  = 1;
  localparam int TD  = 4;
  localparam int DMAX = (1 << CW) - 1;
`ifdef ALLRED_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif
  localparam int S_NIGHT = 0, S_GREEN = 1, S_YELLOW = 2, S_ALLRED = 3;

  logic           clk, rst_n;
  logic [1:0]     mode;
  logic [PHW-1:0] set_phase;
  logic           key_plus, key_sub;
  logic [N-1:0]   red, yellow, green;
  logic [PHW-1:0] phase_o;
  logic [1:0]     state_o;
  logic [CW-1:0]  remain_o, set_val_o;
  logic           tick_o;

  traffic_phase_ctrl #(
    .N_PHASE(N), .PH_W(PHW), .CNT_W(CW), .GREEN_DEF(GD), .YELLOW_DEF(YD),
    .ALLRED_DUR(AR), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .set_phase(set_phase),
    .key_plus(key_plus), .key_sub(key_sub),
    .red(red), .yellow(yellow), .green(green),
    .phase_o(phase_o), .state_o(state_o), .remain_o(remain_o),
    .set_val_o(set_val_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: state as plain integers, seconds counted in ticks,
  // key presses recovered from the last three sampled key levels.
  int       m_state, m_phase, m_cnt, m_ncyc;
  bit       m_flash;
  int       m_grn [N];
  int       m_yel [N];
  bit [2:0] kp_h, ks_h;

  task automatic model_reset();
    m_state = S_NIGHT; m_phase = 0; m_cnt = 0; m_ncyc = 0; m_flash = 0;
    kp_h = '1; ks_h = '1;
    for (int i = 0; i < N; i++) begin m_grn[i] = GD; m_yel[i] = YD; end
  endtask

  task automatic enter(input int st, input int ph);
    m_state = st;
    m_phase = ph;
    if (st == S_GREEN)       m_cnt = m_grn[ph];
    else if (st == S_YELLOW) m_cnt = m_yel[ph];
    else                     m_cnt = (AR < 1) ? 1 : AR;
  endtask

  task automatic model_step();
    bit tk, pe, se;
    int sp, d;
    tk = (m_ncyc % TD) == TD - 1;
    pe = kp_h[2] && !kp_h[1];
    se = ks_h[2] && !ks_h[1];
    if (m_state == S_NIGHT && tk) m_flash = !m_flash;
    if (mode == 2'b01) begin
      m_state = S_NIGHT;
      m_cnt   = 0;
    end else if (m_state == S_NIGHT) begin
      if (mode == 2'b00) enter(S_GREEN, 0);
    end else if (mode == 2'b00 && tk) begin
      if (m_cnt > 1)                        m_cnt = m_cnt - 1;
      else if (m_state == S_GREEN)          enter(S_YELLOW, m_phase);
      else if (m_state == S_YELLOW && AR_EN) enter(S_ALLRED, m_phase);
      else                                  enter(S_GREEN, (m_phase + 1) % N);
    end
    sp = int'(set_phase);
    if (mode[1] && (pe != se) && sp < N) begin
      d = pe ? 1 : -1;
      if (mode[0]) m_yel[sp] = (m_yel[sp] + d < 1) ? 1 : ((m_yel[sp] + d > DMAX) ? DMAX : m_yel[sp] + d);
      else         m_grn[sp] = (m_grn[sp] + d < 1) ? 1 : ((m_grn[sp] + d > DMAX) ? DMAX : m_grn[sp] + d);
    end
    kp_h = {kp_h[1:0], key_plus};
    ks_h = {ks_h[1:0], key_sub};
    m_ncyc++;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  always @(negedge clk) begin
    if (rst_n) begin
      logic [N-1:0] er, ey, eg;
      int sp, esv;
      for (int i = 0; i < N; i++) begin
        eg[i] = (m_state == S_GREEN) && (i == m_phase);
        ey[i] = ((m_state == S_YELLOW) && (i == m_phase)) || ((m_state == S_NIGHT) && m_flash);
        er[i] = (m_state == S_ALLRED) ||
                (((m_state == S_GREEN) || (m_state == S_YELLOW)) && (i != m_phase));
      end
      sp  = int'(set_phase);
      esv = 0;
      if (sp < N && mode == 2'b10) esv = m_grn[sp];
      if (sp < N && mode == 2'b11) esv = m_yel[sp];
      check("state", 32'(state_o), 32'(m_state));
      check("phase", 32'(phase_o), 32'(m_phase));
      check("remain", 32'(remain_o), 32'(m_cnt));
      check("red", 32'(red), 32'(er));
      check("yellow", 32'(yellow), 32'(ey));
      check("green", 32'(green), 32'(eg));
      check("set_val", 32'(set_val_o), 32'(esv));
      check("tick", 32'(tick_o), 32'((m_ncyc % TD) == TD - 1));
    end
  end

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit p, input bit s);
    key_plus = !p;
    key_sub  = !s;
    step_cycles(4);
    key_plus = 1'b1;
    key_sub  = 1'b1;
    step_cycles(4);
  endtask

  task automatic set_dur(input logic [1:0] md, input int ph, input int target);
    int cur;
    mode = md;
    set_phase = PHW'(ph);
    step_cycles(1);
    for (int k = 0; k < 40; k++) begin
      cur = md[0] ? m_yel[ph] : m_grn[ph];
      if (cur == target) break;
      press(cur < target, cur > target);
    end
  endtask

  task automatic wait_until(input int st, input int ph, input int budget);
    for (int k = 0; k < budget; k++) begin
      step_cycles(1);
      if (int'(state_o) == st && int'(phase_o) == ph) break;
    end
    check("reach_state", 32'(state_o), 32'(st));
    check("reach_phase", 32'(phase_o), 32'(ph));
  endtask

  task automatic run_len(output int n);
    logic [1:0]     st;
    logic [PHW-1:0] ph;
    st = state_o;
    ph = phase_o;
    n  = 1;
    while (n < 400) begin
      step_cycles(1);
      if (state_o != st || phase_o != ph) break;
      n++;
    end
  endtask

  initial begin
    int n;
    clk = 0; rst_n = 0; mode = 2'b01; set_phase = '0; key_plus = 1; key_sub = 1;
    model_reset();
    #23;
    check("rst_state", 32'(state_o), 0);
    check("rst_phase", 32'(phase_o), 0);
    check("rst_remain", 32'(remain_o), 0);
    check("rst_lamps", 32'({red, yellow, green}), 0);
    check("rst_tick", 32'(tick_o), 0);
    @(negedge clk);
    #1 rst_n = 1;
    step_cycles(2);

    // Editing green[1]: up three, simultaneous press, then down to the floor.
    mode = 2'b10; set_phase = 3'd1;
    step_cycles(1);
    repeat (3) press(1, 0);
    check("green1_up", 32'(set_val_o), 11);
    press(1, 1);
    check("green1_both", 32'(set_val_o), 11);
    repeat (12) press(0, 1);
    check("green1_floor", 32'(set_val_o), 1);

    for (int p = 0; p < N; p++) begin
      set_dur(2'b10, p, 3);
      set_dur(2'b11, p, 2);
    end

    // Run sequence with green=3, yellow=2 ticks.
    mode = 2'b00;
    wait_until(S_YELLOW, 0, 100);
    run_len(n);
    check("yellow0_len", 32'(n), 8);
`ifdef ALLRED_EN
    check("allred_state", 32'(state_o), S_ALLRED);
    run_len(n);
    check("allred_len", 32'(n), 4);
`endif
    check("green1_state", 32'(state_o), S_GREEN);
    check("green1_phase", 32'(phase_o), 1);
    run_len(n);
    check("green1_len", 32'(n), 12);
    wait_until(S_GREEN, 2, 100);
    wait_until(S_GREEN, 0, 100);
    wait_until(S_GREEN, 1, 100);
    step_cycles(5);

    mode = 2'b01;
    step_cycles(1);
    check("night_state", 32'(state_o), S_NIGHT);
    check("night_rg", 32'({red, green}), 0);
    step_cycles(12);
    mode = 2'b00;
    step_cycles(1);
    check("restart_state", 32'(state_o), S_GREEN);
    check("restart_cnt", 32'(remain_o), 3);

    for (int k = 0; k < 10 && remain_o != 2; k++) step_cycles(1);
    check("freeze_pre", 32'(remain_o), 2);
    mode = 2'b11;
    step_cycles(80);
    check("freeze_cnt", 32'(remain_o), 2);
    check("freeze_green", 32'(green), 1);
    mode = 2'b00;
    wait_until(S_YELLOW, 0, 20);

    // Asynchronous reset in the middle of a cycle.
    step_cycles(1);
    #1 rst_n = 0;
    model_reset();
    #1;
    check("arst_lamps", 32'({red, yellow, green}), 0);
    check("arst_state", 32'(state_o), S_NIGHT);
    mode = 2'b10; set_phase = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1;
    #1;
    check("rel_state", 32'(state_o), S_NIGHT);
    check("rel_green_dur", 32'(set_val_o), GD);
    mode = 2'b11;
    #1;
    check("rel_yellow_dur", 32'(set_val_o), YD);
    step_cycles(1);

    // Randomized mode/key/set_phase traffic checked against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) key_plus = !key_plus;
      if ($urandom_range(0, 3) == 0) key_sub = !key_sub;
      if ($urandom_range(0, 30) == 0) set_phase = PHW'($urandom_range(0, 7));
      step_cycles(1);
    end
    key_plus = 1; key_sub = 1; mode = 2'b00;
    step_cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
